// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Decode-stage hazard and forwarding controller. Every instruction that
// leaves decode gets a record. Records for EXE (stage 0) and the post-EXE
// stages 1..FWD_STAGES shift forward one stage per clock.
// From those records the unit produces:
//   - load-use stalls,
//   - nearest-producer forwarding selects for both EXE operands,
//   - decode-redirect flushes.
// It also carries the opaque decode control bundle into the ID/EX register.
//
// Parameters:
//   REG_ADDR_WIDTH  register address width
//   CTRL_WIDTH      width of the decode->execute control bundle
//   FWD_STAGES      post-EXE stages tracked (1 = MEM ... FWD_STAGES = WB)
//   LOAD_LAT        load data first forwardable from stage LOAD_LAT+1;
//                   the legal range is 1..FWD_STAGES-1
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dec_valid, dec_ctrl      decode instruction valid / control bundle
//   dec_rs1/rs2, dec_use_*   decode source addresses and read flags
//   dec_rd, dec_reg_en       decode destination and write enable
//   dec_is_load              decode instruction is a load
//   redirect                 control transfer resolved in decode
//   exe_valid, exe_ctrl      ID/EX register contents
//   fwd_a_sel, fwd_b_sel     0 = register file, k = forward from stage k
//   stall_if, flush_if       hold / squash PC and IF/ID
//   wb_rd, wb_reg_en         destination and write enable in the last stage
//
// Optional feature: when HAZARD_PERF_CNT_EN is defined, the unit adds two
// saturating 32-bit counters, perf_stall_cnt and perf_flush_cnt.
module hazard_fwd_unit #(
  parameter int  REG_ADDR_WIDTH = 5,
  parameter int  CTRL_WIDTH     = 16,
  parameter int  FWD_STAGES     = 2,
  parameter int  LOAD_LAT       = 1,
  localparam int SEL_WIDTH      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [CTRL_WIDTH-1:0]     dec_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
  input  logic                      dec_use_rs1,
  input  logic                      dec_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
  input  logic                      dec_reg_en,
  input  logic                      dec_is_load,
  input  logic                      redirect,
  output logic                      exe_valid,
  output logic [CTRL_WIDTH-1:0]     exe_ctrl,
  output logic [SEL_WIDTH-1:0]      fwd_a_sel,
  output logic [SEL_WIDTH-1:0]      fwd_b_sel,
  output logic                      stall_if,
  output logic                      flush_if,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_reg_en
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_flush_cnt
`endif
);

  // A load has to be forwardable from some tracked stage; otherwise the
  // result could never reach a consumer.
  if (LOAD_LAT < 1 || LOAD_LAT > FWD_STAGES - 1) begin : g_bad_load_lat
    $error("hazard_fwd_unit: LOAD_LAT must be within 1..FWD_STAGES-1");
  end

  logic [FWD_STAGES:0]       st_valid;
  logic [FWD_STAGES:0]       st_reg_en;
  logic [FWD_STAGES:0]       st_is_load;
  logic [REG_ADDR_WIDTH-1:0] st_rd [FWD_STAGES+1];
  logic [REG_ADDR_WIDTH-1:0] exe_rs1;
  logic [REG_ADDR_WIDTH-1:0] exe_rs2;

  logic [FWD_STAGES:0]       live;
  logic                      load_hit;
  logic                      issue;
  logic                      blk_a;
  logic                      blk_b;

  // Stage s can produce a value at all. x0 never counts as a producer.
  always_comb begin
    live = '0;
    for (int s = 0; s <= FWD_STAGES; s++) begin
      live[s] = st_valid[s] && st_reg_en[s] && (st_rd[s] != '0);
    end
  end

  // A load younger than LOAD_LAT stages has no data yet, so decode must hold.
  always_comb begin
    load_hit = 1'b0;
    for (int s = 0; s < LOAD_LAT; s++) begin
      if (live[s] && st_is_load[s] &&
          ((dec_use_rs1 && st_rd[s] == dec_rs1) ||
           (dec_use_rs2 && st_rd[s] == dec_rs2))) begin
        load_hit = 1'b1;
      end
    end
  end

  assign stall_if = dec_valid & load_hit;
  assign issue    = dec_valid & ~stall_if;
  // A stall takes priority: a redirect seen while stalled is re-presented
  // by the held decode stage once the stall clears.
  assign flush_if = redirect & dec_valid & ~stall_if;

  // The walk goes from oldest to youngest stage, so the nearest producer
  // overrides older ones. A matching load that is still too young blocks
  // older producers and selects the register file. The stall logic makes
  // this case unreachable, and the assertion below checks that.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    blk_a     = 1'b0;
    blk_b     = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (live[k] && st_rd[k] == exe_rs1) begin
        if (st_is_load[k] && k <= LOAD_LAT) begin
          fwd_a_sel = '0;
          blk_a     = 1'b1;
        end else begin
          fwd_a_sel = SEL_WIDTH'(k);
          blk_a     = 1'b0;
        end
      end
      if (live[k] && st_rd[k] == exe_rs2) begin
        if (st_is_load[k] && k <= LOAD_LAT) begin
          fwd_b_sel = '0;
          blk_b     = 1'b1;
        end else begin
          fwd_b_sel = SEL_WIDTH'(k);
          blk_b     = 1'b0;
        end
      end
    end
  end

  // Records move one stage per clock with no back-pressure. Unused sources
  // are stored as x0, so they can never pick up a forward. A stall or an
  // empty decode slot inserts a bubble into EXE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid   <= '0;
      st_reg_en  <= '0;
      st_is_load <= '0;
      for (int s = 0; s <= FWD_STAGES; s++) begin
        st_rd[s] <= '0;
      end
      exe_rs1  <= '0;
      exe_rs2  <= '0;
      exe_ctrl <= '0;
    end else begin
      for (int s = 1; s <= FWD_STAGES; s++) begin
        st_valid[s]   <= st_valid[s-1];
        st_reg_en[s]  <= st_reg_en[s-1];
        st_is_load[s] <= st_is_load[s-1];
        st_rd[s]      <= st_rd[s-1];
      end
      if (issue) begin
        st_valid[0]   <= 1'b1;
        st_reg_en[0]  <= dec_reg_en;
        st_is_load[0] <= dec_is_load;
        st_rd[0]      <= dec_rd;
        exe_rs1       <= dec_use_rs1 ? dec_rs1 : '0;
        exe_rs2       <= dec_use_rs2 ? dec_rs2 : '0;
        exe_ctrl      <= dec_ctrl;
      end else begin
        st_valid[0]   <= 1'b0;
        st_reg_en[0]  <= 1'b0;
        st_is_load[0] <= 1'b0;
        st_rd[0]      <= '0;
        exe_rs1       <= '0;
        exe_rs2       <= '0;
        exe_ctrl      <= '0;
      end
    end
  end

  assign exe_valid = st_valid[0];
  assign wb_rd     = st_rd[FWD_STAGES];
  assign wb_reg_en = st_valid[FWD_STAGES] & st_reg_en[FWD_STAGES];

`ifdef HAZARD_PERF_CNT_EN
  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && perf_stall_cnt != 32'hFFFF_FFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_if && perf_flush_cnt != 32'hFFFF_FFFF) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // An EXE operand must never match a load that is still too young to forward.
  a_no_blocked_fwd: assert property (@(posedge clk) disable iff (rst) !(blk_a || blk_b));
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// Self-checking bench for hazard_fwd_unit with the default geometry
// (FWD_STAGES = 2, LOAD_LAT = 1). Directed scenarios compare against
// hand-derived constants. A randomized run compares every output against a
// history-based reference model, in which hist[d] is the instruction that
// entered EXE d cycles ago.
module tb_hazard_fwd_unit;

  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int FWD = 2;
  localparam int LL  = 1;
  localparam int SW  = $clog2(FWD + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [CW-1:0] dec_ctrl;
  logic [RW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          dec_use_rs1, dec_use_rs2, dec_reg_en, dec_is_load, redirect;
  logic          exe_valid;
  logic [CW-1:0] exe_ctrl;
  logic [SW-1:0] fwd_a_sel, fwd_b_sel;
  logic          stall_if, flush_if;
  logic [RW-1:0] wb_rd;
  logic          wb_reg_en;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_fwd_unit #(
    .REG_ADDR_WIDTH(RW), .CTRL_WIDTH(CW), .FWD_STAGES(FWD), .LOAD_LAT(LL)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ctrl(dec_ctrl),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_reg_en(dec_reg_en), .dec_is_load(dec_is_load),
    .redirect(redirect),
    .exe_valid(exe_valid), .exe_ctrl(exe_ctrl),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .flush_if(flush_if),
    .wb_rd(wb_rd), .wb_reg_en(wb_reg_en)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the sequence of instructions that entered EXE,
  // youngest first. Bubbles are all-zero entries.
  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ld;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [CW-1:0] ctrl;
  } ins_t;

  ins_t hist[$];

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i <= FWD; i++) hist.push_back('0);
  endfunction

  function automatic bit writes(ins_t e, logic [RW-1:0] r);
    return e.v && e.wr && (e.rd != 0) && (e.rd == r);
  endfunction

  function automatic bit m_stall();
    if (!dec_valid) return 1'b0;
    for (int d = 0; d < LL; d++) begin
      if (hist[d].ld && ((dec_use_rs1 && writes(hist[d], dec_rs1)) ||
                         (dec_use_rs2 && writes(hist[d], dec_rs2))))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_sel(logic [RW-1:0] r);
    for (int d = 1; d <= FWD; d++) begin
      if (writes(hist[d], r)) return (hist[d].ld && d <= LL) ? 0 : d;
    end
    return 0;
  endfunction

  function automatic void model_update();
    ins_t n;
    n = '0;
    if (dec_valid && !m_stall()) begin
      n.v    = 1'b1;
      n.rd   = dec_rd;
      n.wr   = dec_reg_en;
      n.ld   = dec_is_load;
      n.rs1  = dec_use_rs1 ? dec_rs1 : '0;
      n.rs2  = dec_use_rs2 ? dec_rs2 : '0;
      n.ctrl = dec_ctrl;
    end
    hist.push_front(n);
    void'(hist.pop_back());
  endfunction

  // Apply decode inputs, then wait for the sampling point (negedge).
  task automatic drive(input logic v, input logic [RW-1:0] rd, input logic wr,
                       input logic ld, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2,
                       input logic redir, input logic [CW-1:0] ctrl);
    dec_valid = v;    dec_rd = rd;       dec_reg_en = wr;  dec_is_load = ld;
    dec_rs1 = rs1;    dec_use_rs1 = u1;  dec_rs2 = rs2;    dec_use_rs2 = u2;
    redirect = redir; dec_ctrl = ctrl;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dec_valid = 0; dec_ctrl = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_reg_en = 0; dec_is_load = 0; redirect = 0;
    model_reset();
    @(negedge clk);
    total++; if (exe_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_exe_valid got=%0b want=0", exe_valid); end
    total++; if (exe_ctrl !== '0) begin bad++; $display("[TB] FAIL rst_exe_ctrl got=%h want=0", exe_ctrl); end
    total++; if (wb_reg_en !== 1'b0 || wb_rd !== '0) begin bad++; $display("[TB] FAIL rst_wb got=%0b/%0d want=0/0", wb_reg_en, wb_rd); end
    total++; if (stall_if !== 1'b0 || flush_if !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_flush got=%0b/%0b want=0/0", stall_if, flush_if); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_chain();
    idle(FWD + 1);
    drive(1, 5, 1, 0, 1, 1, 2, 1, 0, 16'h0101);
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL alu_stall0 got=%0b want=0", stall_if); end
    tick();
    drive(1, 6, 1, 0, 5, 1, 5, 1, 0, 16'h0202);
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL alu_stall1 got=%0b want=0", stall_if); end
    tick();
    drive(1, 7, 1, 0, 5, 1, 0, 1, 0, 16'h0303);
    total++; if (fwd_a_sel !== SW'(1) || fwd_b_sel !== SW'(1)) begin bad++; $display("[TB] FAIL alu_fwd1 got=%0d/%0d want=1/1", fwd_a_sel, fwd_b_sel); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (fwd_a_sel !== SW'(2) || fwd_b_sel !== SW'(0)) begin bad++; $display("[TB] FAIL alu_fwd2 got=%0d/%0d want=2/0", fwd_a_sel, fwd_b_sel); end
    tick();
  endtask

  task automatic test_load_use();
    idle(FWD + 1);
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 16'h1111);
    tick();
    drive(1, 8, 1, 0, 7, 1, 0, 1, 0, 16'h2222);
    total++; if (stall_if !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0b want=1", stall_if); end
    tick();
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall_len got=%0b want=0", stall_if); end
    total++; if (exe_valid !== 1'b0 || exe_ctrl !== '0) begin bad++; $display("[TB] FAIL lu_bubble got=%0b/%h want=0/0", exe_valid, exe_ctrl); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (exe_valid !== 1'b1 || exe_ctrl !== 16'h2222) begin bad++; $display("[TB] FAIL lu_issue got=%0b/%h want=1/2222", exe_valid, exe_ctrl); end
    total++; if (fwd_a_sel !== SW'(2)) begin bad++; $display("[TB] FAIL lu_fwd got=%0d want=2", fwd_a_sel); end
    tick();
  endtask

  task automatic test_x0_unused();
    idle(FWD + 1);
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0033);
    tick();
    drive(1, 9, 1, 0, 0, 1, 0, 1, 0, 16'h0044);
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL x0_stall got=%0b want=0", stall_if); end
    tick();
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 16'h0055);
    tick();
    drive(1, 4, 1, 0, 0, 0, 3, 0, 0, 16'h0066);
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL unused_stall got=%0b want=0", stall_if); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (fwd_a_sel !== '0 || fwd_b_sel !== '0) begin bad++; $display("[TB] FAIL unused_fwd got=%0d/%0d want=0/0", fwd_a_sel, fwd_b_sel); end
    tick();
  endtask

  task automatic test_priority();
    idle(FWD + 1);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0A01);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0A02);
    tick();
    drive(1, 10, 1, 0, 9, 1, 9, 1, 0, 16'h0A03);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (fwd_a_sel !== SW'(1) || fwd_b_sel !== SW'(1)) begin bad++; $display("[TB] FAIL prio got=%0d/%0d want=1/1", fwd_a_sel, fwd_b_sel); end
    tick();
  endtask

  task automatic test_redirect();
    idle(FWD + 1);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 16'hA5A5);
    total++; if (flush_if !== 1'b1 || stall_if !== 1'b0) begin bad++; $display("[TB] FAIL jal_flush got=%0b/%0b want=1/0", flush_if, stall_if); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (exe_valid !== 1'b1 || exe_ctrl !== 16'hA5A5) begin bad++; $display("[TB] FAIL jal_issue got=%0b/%h want=1/a5a5", exe_valid, exe_ctrl); end
    total++; if (flush_if !== 1'b0) begin bad++; $display("[TB] FAIL jal_flush_len got=%0b want=0", flush_if); end
    tick();
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (wb_reg_en !== 1'b1 || wb_rd !== 5'd1) begin bad++; $display("[TB] FAIL jal_wb got=%0b/%0d want=1/1", wb_reg_en, wb_rd); end
    tick();
  endtask

  task automatic test_redirect_stall();
    do_reset();
    drive(1, 4, 1, 1, 0, 0, 0, 0, 0, 16'hBB01);
    tick();
    drive(1, 0, 0, 0, 4, 1, 0, 1, 1, 16'hBB02);
    total++; if (stall_if !== 1'b1 || flush_if !== 1'b0) begin bad++; $display("[TB] FAIL rs_held got=%0b/%0b want=1/0", stall_if, flush_if); end
    tick();
    total++; if (stall_if !== 1'b0 || flush_if !== 1'b1) begin bad++; $display("[TB] FAIL rs_release got=%0b/%0b want=0/1", stall_if, flush_if); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (exe_valid !== 1'b1 || exe_ctrl !== 16'hBB02) begin bad++; $display("[TB] FAIL rs_issue got=%0b/%h want=1/bb02", exe_valid, exe_ctrl); end
`ifdef HAZARD_PERF_CNT_EN
    total++; if (perf_stall_cnt !== 32'd1 || perf_flush_cnt !== 32'd1) begin bad++; $display("[TB] FAIL perf_cnt got=%0d/%0d want=1/1", perf_stall_cnt, perf_flush_cnt); end
`endif
    tick();
  endtask

  task automatic test_reset_midstream();
    idle(FWD + 1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 16'hC001);
    tick();
    drive(1, 6, 1, 0, 5, 1, 0, 0, 0, 16'hC002);
    tick();
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 16'hC003);
    tick();
    drive(1, 8, 1, 0, 7, 1, 0, 0, 0, 16'hC004);
    total++; if (stall_if !== 1'b1 || wb_reg_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre got=%0b/%0b want=1/1", stall_if, wb_reg_en); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (exe_valid !== 1'b0 || wb_reg_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid got=%0b/%0b want=0/0", exe_valid, wb_reg_en); end
    total++; if (fwd_a_sel !== '0 || fwd_b_sel !== '0) begin bad++; $display("[TB] FAIL mid_rst_fwd got=%0d/%0d want=0/0", fwd_a_sel, fwd_b_sel); end
    total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_stall got=%0b want=0", stall_if); end
    model_reset();
    dec_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int ea, eb;
    bit es, ef;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 8), RW'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 9) < 3), RW'($urandom_range(0, 7)), 1'($urandom),
            RW'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 9) == 0),
            CW'($urandom));
      es = m_stall();
      ef = redirect && dec_valid && !es;
      ea = m_sel(hist[0].rs1);
      eb = m_sel(hist[0].rs2);
      total++; if (stall_if !== es) begin bad++; $display("[TB] FAIL rnd_stall i=%0d got=%0b want=%0b", i, stall_if, es); end
      total++; if (flush_if !== ef) begin bad++; $display("[TB] FAIL rnd_flush i=%0d got=%0b want=%0b", i, flush_if, ef); end
      total++; if (fwd_a_sel !== SW'(ea)) begin bad++; $display("[TB] FAIL rnd_fwd_a i=%0d got=%0d want=%0d", i, fwd_a_sel, ea); end
      total++; if (fwd_b_sel !== SW'(eb)) begin bad++; $display("[TB] FAIL rnd_fwd_b i=%0d got=%0d want=%0d", i, fwd_b_sel, eb); end
      total++; if (exe_valid !== hist[0].v) begin bad++; $display("[TB] FAIL rnd_exe_valid i=%0d got=%0b want=%0b", i, exe_valid, hist[0].v); end
      total++; if (exe_ctrl !== hist[0].ctrl) begin bad++; $display("[TB] FAIL rnd_exe_ctrl i=%0d got=%h want=%h", i, exe_ctrl, hist[0].ctrl); end
      total++; if (wb_rd !== hist[FWD].rd) begin bad++; $display("[TB] FAIL rnd_wb_rd i=%0d got=%0d want=%0d", i, wb_rd, hist[FWD].rd); end
      total++; if (wb_reg_en !== (hist[FWD].v && hist[FWD].wr)) begin bad++; $display("[TB] FAIL rnd_wb_en i=%0d got=%0b want=%0b", i, wb_reg_en, hist[FWD].v && hist[FWD].wr); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting hazard_fwd_unit bench");
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_unused();
    test_priority();
    test_redirect();
    test_redirect_stall();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
